// File: rtl/uart_rx.sv
// 8N1 serial receiver driven by a baud_gen oversample tick; LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t               state, next_state;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_sample, word_ok, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit, parity_bad;
`endif

  // Sync flops preset to the idle level so reset release never looks like a start edge.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      state   <= IDLE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      state   <= next_state;
    end
  end

  // NOTE: next_state gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    if (tick) begin
      unique case (state)
        IDLE:  if (!rx_s) next_state = START;
        START: if (tick_cnt == MID_TICK) next_state = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        DATA:   if (tick_cnt == LAST_TICK && bit_cnt == LAST_BIT) next_state = PARITY;
        PARITY: if (tick_cnt == LAST_TICK) next_state = STOP;
`else
        DATA:  if (tick_cnt == LAST_TICK && bit_cnt == LAST_BIT) next_state = STOP;
`endif
        STOP:  if (tick_cnt == LAST_TICK) next_state = rx_s ? IDLE : BREAK;
        BREAK: if (rx_s) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    stop_sample = tick && (state == STOP) && (tick_cnt == LAST_TICK);
    frame_bad   = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    parity_bad  = stop_sample && rx_s && (^{shreg, parity_bit});
    word_ok     = stop_sample && rx_s && !(^{shreg, parity_bit});
`else
    word_ok     = stop_sample && rx_s;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      data_valid <= word_ok;
      frame_err  <= frame_bad;
`ifdef UART_RX_PARITY_EN
      parity_err <= parity_bad;
`endif
      if (word_ok) data_out <= shreg;
      if (tick) begin
        // Counter restarts at every bit boundary and whenever the line is re-armed.
        if (state == IDLE || state == BREAK || tick_cnt == LAST_TICK ||
            (state == START && tick_cnt == MID_TICK))
          tick_cnt <= '0;
        else
          tick_cnt <= tick_cnt + 1'b1;
        if (state == START) bit_cnt <= '0;
        if (state == DATA && tick_cnt == LAST_TICK) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        if (state == PARITY && tick_cnt == LAST_TICK) parity_bit <= rx_s;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit by bit from plain byte values
// and the received words are compared against a queue of expected bytes.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int tick_period = 4;

  logic [DB-1:0] got_q[$];
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int both_cnt = 0;
  logic [DB-1:0] last_good = '0;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (cnt >= tick_period - 1) begin
        tick = 1'b1;
        cnt = 0;
      end else begin
        tick = 1'b0;
        cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (data_valid === 1'b1) got_q.push_back(data_out);
    if (frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) perr_cnt++;
`endif
    if (data_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
  endtask

  task automatic send_bit(input logic v);
    @(negedge clk);
    rx = v;
    wait_ticks(OS);
  endtask

  task automatic send_data_stop(input logic [DB-1:0] d, input logic stop, input logic par);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    send_data_stop(d, stop, par);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run += 4;
    if (data_out !== '0) begin tests_failed++; $display("FAIL reset_data_out: got %h required 00", data_out); end
    if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_data_valid: got %b required 0", data_valid); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b required 0", busy); end
`ifdef UART_RX_PARITY_EN
    tests_run++;
    if (parity_err !== 1'b0) begin tests_failed++; $display("FAIL reset_parity_err: got %b required 0", parity_err); end
`endif
    rst_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_single_byte;
    int base = got_q.size();
    int f0 = ferr_cnt;
    logic [DB-1:0] d = 8'hA5;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_mid: got %b required 1", busy); end
    wait_ticks(OS - 4);
    send_data_stop(d, 1'b1, ^d);
    wait_ticks(2);
    @(negedge clk);
    tests_run += 4;
    if (got_q.size() - base != 1) begin
      tests_failed++; $display("FAIL single_count: got %0d strobes required 1", got_q.size() - base);
    end else if (got_q[base] !== d) begin
      tests_failed++; $display("FAIL single_word: got %h required %h", got_q[base], d);
    end
    if (data_out !== d) begin tests_failed++; $display("FAIL single_data_out: got %h required %h", data_out, d); end
    if (ferr_cnt != f0) begin tests_failed++; $display("FAIL single_frame_err: got %0d pulses required 0", ferr_cnt - f0); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_after: got %b required 0", busy); end
    last_good = d;
  endtask

  task automatic test_back_to_back;
    logic [DB-1:0] exp_q[$];
    int base = got_q.size();
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, ^exp_q[i]);
    wait_ticks(2);
    tests_run++;
    if (got_q.size() - base != exp_q.size()) begin
      tests_failed++; $display("FAIL b2b_count: got %0d strobes required %0d", got_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[base + i] !== exp_q[i]) begin
          tests_failed++; $display("FAIL b2b_word%0d: got %h required %h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
    last_good = exp_q[exp_q.size() - 1];
  endtask

  task automatic test_false_start;
    int base = got_q.size();
    int f0 = ferr_cnt;
    logic [DB-1:0] d = 8'h55;
    @(negedge clk);
    rx = 1'b0;
    wait_ticks(5);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(20);
    @(negedge clk);
    tests_run += 3;
    if (got_q.size() != base) begin tests_failed++; $display("FAIL false_start_valid: got %0d strobes required 0", got_q.size() - base); end
    if (ferr_cnt != f0) begin tests_failed++; $display("FAIL false_start_ferr: got %0d pulses required 0", ferr_cnt - f0); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL false_start_busy: got %b required 0", busy); end
    send_frame(d, 1'b1, ^d);
    wait_ticks(2);
    tests_run++;
    if (got_q.size() - base != 1 || got_q[got_q.size() - 1] !== d) begin
      tests_failed++; $display("FAIL false_start_next: got %0d strobes last %h required 1 strobe %h",
                               got_q.size() - base, data_out, d);
    end
    last_good = d;
  endtask

  task automatic test_frame_error;
    int base = got_q.size();
    int f0 = ferr_cnt;
    logic [DB-1:0] bad = 8'h81;
    logic [DB-1:0] d = 8'h12;
    send_frame(bad, 1'b0, ^bad);
    wait_ticks(40);
    @(negedge clk);
    rx = 1'b1;
    wait_ticks(4);
    @(negedge clk);
    tests_run += 3;
    if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL ferr_count: got %0d pulses required 1", ferr_cnt - f0); end
    if (got_q.size() != base) begin tests_failed++; $display("FAIL ferr_valid: got %0d strobes required 0", got_q.size() - base); end
    if (data_out !== last_good) begin tests_failed++; $display("FAIL ferr_data_kept: got %h required %h", data_out, last_good); end
    send_frame(d, 1'b1, ^d);
    wait_ticks(2);
    tests_run++;
    if (got_q.size() - base != 1 || got_q[got_q.size() - 1] !== d) begin
      tests_failed++; $display("FAIL ferr_next: got %0d strobes data %h required 1 strobe %h", got_q.size() - base, data_out, d);
    end
    last_good = d;
  endtask

  task automatic test_reset_mid_frame;
    logic [DB-1:0] d = 8'hF0;
    logic [DB-1:0] nd = 8'h0F;
    int base;
    int f0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    @(negedge clk);
    rx = d[3];
    wait_ticks(6);
    #1 rst_n = 1'b0;
    #1;
    tests_run += 4;
    if (data_out !== '0) begin tests_failed++; $display("FAIL midrst_data_out: got %h required 00", data_out); end
    if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_data_valid: got %b required 0", data_valid); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL midrst_frame_err: got %b required 0", frame_err); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b required 0", busy); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = '0;
    base = got_q.size();
    f0 = ferr_cnt;
    wait_ticks(4);
    send_frame(nd, 1'b1, ^nd);
    wait_ticks(2);
    tests_run += 2;
    if (got_q.size() - base != 1 || got_q[got_q.size() - 1] !== nd) begin
      tests_failed++; $display("FAIL midrst_next: got %0d strobes data %h required 1 strobe %h", got_q.size() - base, data_out, nd);
    end
    if (ferr_cnt != f0) begin tests_failed++; $display("FAIL midrst_ferr: got %0d pulses required 0", ferr_cnt - f0); end
    last_good = nd;
  endtask

  task automatic test_random;
    logic [DB-1:0] exp_q[$];
    int base = got_q.size();
    for (int k = 0; k < 8; k++) begin
      logic [DB-1:0] d = DB'($urandom_range(0, 255));
      tick_period = (k % 2 == 1) ? 1 : 4;
      wait_ticks($urandom_range(0, 10));
      send_frame(d, 1'b1, ^d);
      exp_q.push_back(d);
    end
    wait_ticks(2);
    tick_period = 4;
    tests_run++;
    if (got_q.size() - base != exp_q.size()) begin
      tests_failed++; $display("FAIL rand_count: got %0d strobes required %0d", got_q.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (got_q[base + i] !== exp_q[i]) begin
          tests_failed++; $display("FAIL rand_word%0d: got %h required %h", i, got_q[base + i], exp_q[i]);
        end
      end
    end
    last_good = exp_q[exp_q.size() - 1];
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    logic [DB-1:0] d = 8'h07;
    int base = got_q.size();
    int p0 = perr_cnt;
    wait_ticks(4);
    send_frame(d, 1'b1, 1'b0);
    wait_ticks(2);
    @(negedge clk);
    tests_run += 3;
    if (perr_cnt - p0 != 1) begin tests_failed++; $display("FAIL parity_err_count: got %0d pulses required 1", perr_cnt - p0); end
    if (got_q.size() != base) begin tests_failed++; $display("FAIL parity_valid: got %0d strobes required 0", got_q.size() - base); end
    if (data_out !== last_good) begin tests_failed++; $display("FAIL parity_data_kept: got %h required %h", data_out, last_good); end
    send_frame(d, 1'b1, 1'b1);
    wait_ticks(2);
    @(negedge clk);
    tests_run += 2;
    if (got_q.size() - base != 1 || data_out !== d) begin
      tests_failed++; $display("FAIL parity_good: got %0d strobes data %h required 1 strobe %h", got_q.size() - base, data_out, d);
    end
    if (perr_cnt - p0 != 1) begin tests_failed++; $display("FAIL parity_good_err: got %0d pulses required 1", perr_cnt - p0); end
    last_good = d;
  endtask
`endif

  task automatic test_strobe_exclusive;
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++; $display("FAIL strobe_exclusive: got %0d overlaps required 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_strobe_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
